// File: rtl/difftest_gate_pkg.sv
// Shared types and helpers for the DiffTest clock-gate enable controller.
package difftest_gate_pkg;

    // Controller states; the encoding is exposed on the debug state port.
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } gate_state_e;

    // Width of the shared WAKE/HOLD down-counter. It only ever holds
    // values up to max(wake, hold) - 1, and is never narrower than one bit.
    function automatic int cnt_width(input int wake, input int hold);
        int m;
        m = (wake > hold) ? wake : hold;
        if (m <= 2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/difftest_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module difftest_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] r_value;

    // Count register: clear first, then increment until all-ones, then hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_value <= {W{1'b0}};
        end else if (clear) begin
            r_value <= {W{1'b0}};
        end else if (inc && (r_value != ALL_ONES)) begin
            r_value <= r_value + ONE;
        end else begin
            r_value <= r_value;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/difftest_gate_ctrl.sv
// Clock-gate enable controller: merges requester levels into one registered
// enable with a warm-up delay before ack and an idle hold-off before shutdown.
module difftest_gate_ctrl
    import difftest_gate_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               force_on,
    input  logic               cnt_clear,
    output logic               gate_en,
    output logic               ack,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   gated_cycles
);

    localparam int            CW        = cnt_width(WAKE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    gate_state_e   r_state;
    gate_state_e   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_gate_en;
    logic          r_ack;
    logic          w_any_req;
    logic          w_cnt_inc;

    assign w_any_req = (|req) | force_on;

    // Next-state and shared down-counter update for the WAKE/HOLD timers.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_OFF: begin
                if (w_any_req) begin
                    w_state_nxt = ST_WAKE;
                    w_cnt_nxt   = WAKE_LOAD;
                end else begin
                    w_state_nxt = ST_OFF;
                end
            end
            ST_WAKE: begin
                // Warm-up always completes, even if the request went away.
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_ON;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_ON: begin
                if (!w_any_req) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_LOAD;
                end else begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_HOLD: begin
                // A returning request beats expiry so the enable never dips.
                if (w_any_req) begin
                    w_state_nxt = ST_ON;
                end else if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State and timer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_OFF;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Enable and ack are their own flops, decoded from the next state, so a
    // two-bit state change can never glitch the clock-gate E pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_gate_en <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_gate_en <= (w_state_nxt != ST_OFF);
            r_ack     <= (w_state_nxt == ST_ON) || (w_state_nxt == ST_HOLD);
        end
    end

    assign w_cnt_inc = ~r_gate_en;

    difftest_sat_counter #(
        .W (CNT_W)
    ) u_gated_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (w_cnt_inc),
        .value (gated_cycles)
    );

    assign gate_en = r_gate_en;
    assign ack     = r_ack;
    assign state   = r_state;

endmodule

// File: tb/tb_difftest_gate_ctrl.sv
// Directed scoreboard bench for difftest_gate_ctrl.
module tb_difftest_gate_ctrl;

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_WAKE = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic        force_on;
    logic        cnt_clear;
    logic        gate_en;
    logic        ack;
    logic [1:0]  state;
    logic [31:0] gated_cycles;

    logic        r4;
    logic [3:0]  req4;
    logic        force4;
    logic        clear4;
    logic        gate_en4;
    logic        ack4;
    logic [1:0]  state4;
    logic [3:0]  gc4;

    int tests;
    int failed;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        ge;
        logic        ak;
        logic [31:0] gc;
        bit          chk_gc;
        bit          sel4;
    } exp_t;

    exp_t sb[$];

    difftest_gate_ctrl u_dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .force_on     (force_on),
        .cnt_clear    (cnt_clear),
        .gate_en      (gate_en),
        .ack          (ack),
        .state        (state),
        .gated_cycles (gated_cycles)
    );

    difftest_gate_ctrl #(.CNT_W(4)) u_dut4 (
        .clock        (clock),
        .reset        (r4),
        .req          (req4),
        .force_on     (force4),
        .cnt_clear    (clear4),
        .gate_en      (gate_en4),
        .ack          (ack4),
        .state        (state4),
        .gated_cycles (gc4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [1:0] st, input logic ge,
                        input logic ak, input logic [31:0] gc, input bit chk_gc,
                        input bit sel4);
        exp_t e;
        e.tag = tag; e.st = st; e.ge = ge; e.ak = ak;
        e.gc = gc; e.chk_gc = chk_gc; e.sel4 = sel4;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL sb_empty got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            if (e.sel4) begin
                tests++;
                assert ({28'd0, gc4} === e.gc) else begin
                    failed++;
                    $error("FAIL %s gated_cycles got %0d want %0d", e.tag, gc4, e.gc);
                end
            end else begin
                tests += 3;
                assert (state === e.st) else begin
                    failed++;
                    $error("FAIL %s state got %0d want %0d", e.tag, state, e.st);
                end
                assert (gate_en === e.ge) else begin
                    failed++;
                    $error("FAIL %s gate_en got %b want %b", e.tag, gate_en, e.ge);
                end
                assert (ack === e.ak) else begin
                    failed++;
                    $error("FAIL %s ack got %b want %b", e.tag, ack, e.ak);
                end
                if (e.chk_gc) begin
                    tests++;
                    assert (gated_cycles === e.gc) else begin
                        failed++;
                        $error("FAIL %s gated_cycles got %0d want %0d", e.tag, gated_cycles, e.gc);
                    end
                end
            end
        end
    endtask

    task automatic exp_step(input string tag, input logic [1:0] st, input logic ge,
                            input logic ak, input logic [31:0] gc, input bit chk_gc);
        push(tag, st, ge, ak, gc, chk_gc, 1'b0);
        step();
        check();
    endtask

    task automatic exp_step4(input string tag, input logic [31:0] gc);
        push(tag, 2'd0, 1'b0, 1'b0, gc, 1'b1, 1'b1);
        step();
        check();
    endtask

    initial begin
        tests = 0; failed = 0;
        reset = 1'b1; r4 = 1'b1;
        req = 4'd0; force_on = 1'b0; cnt_clear = 1'b0;
        req4 = 4'd0; force4 = 1'b0; clear4 = 1'b0;

        #12;
        push("reset", S_OFF, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check();
        reset = 1'b0;

        // 100 idle edges after release
        repeat (99) step();
        exp_step("idle100", S_OFF, 1'b0, 1'b0, 32'd100, 1'b1);
        cnt_clear = 1'b1;
        exp_step("clear", S_OFF, 1'b0, 1'b0, 32'd0, 1'b1);
        cnt_clear = 1'b0;

        // wake on req[0]
        req = 4'b0001;
        exp_step("wake_e0", S_WAKE, 1'b1, 1'b0, 32'd1, 1'b1);
        exp_step("wake_e1", S_WAKE, 1'b1, 1'b0, 32'd1, 1'b1);
        exp_step("wake_on", S_ON, 1'b1, 1'b1, 32'd1, 1'b1);
        exp_step("on_keep", S_ON, 1'b1, 1'b1, 32'd1, 1'b1);

        // sleep after HOLD_CYCLES
        req = 4'b0000;
        exp_step("sleep_hold", S_HOLD, 1'b1, 1'b1, 32'd1, 1'b1);
        for (int i = 0; i < 15; i++) exp_step("sleep_cnt", S_HOLD, 1'b1, 1'b1, 32'd1, 1'b1);
        exp_step("sleep_off", S_OFF, 1'b0, 1'b0, 32'd1, 1'b1);
        exp_step("off_count", S_OFF, 1'b0, 1'b0, 32'd2, 1'b1);

        // re-request exactly at HOLD expiry
        req = 4'b0010;
        exp_step("rq_wake0", S_WAKE, 1'b1, 1'b0, 32'd0, 1'b0);
        exp_step("rq_wake1", S_WAKE, 1'b1, 1'b0, 32'd0, 1'b0);
        exp_step("rq_on", S_ON, 1'b1, 1'b1, 32'd0, 1'b0);
        req = 4'b0000;
        exp_step("rq_hold", S_HOLD, 1'b1, 1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 15; i++) exp_step("rq_hold_cnt", S_HOLD, 1'b1, 1'b1, 32'd0, 1'b0);
        req = 4'b0100;
        exp_step("rq_win", S_ON, 1'b1, 1'b1, 32'd0, 1'b0);
        exp_step("rq_stay", S_ON, 1'b1, 1'b1, 32'd0, 1'b0);
        req = 4'b0000;
        exp_step("rq_hold2", S_HOLD, 1'b1, 1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 15; i++) exp_step("rq_hold2_cnt", S_HOLD, 1'b1, 1'b1, 32'd0, 1'b0);
        exp_step("rq_off", S_OFF, 1'b0, 1'b0, 32'd0, 1'b0);

        // force_on acts like a request
        force_on = 1'b1;
        exp_step("fo_wake0", S_WAKE, 1'b1, 1'b0, 32'd0, 1'b0);
        exp_step("fo_wake1", S_WAKE, 1'b1, 1'b0, 32'd0, 1'b0);
        exp_step("fo_on", S_ON, 1'b1, 1'b1, 32'd0, 1'b0);
        force_on = 1'b0;
        exp_step("fo_hold", S_HOLD, 1'b1, 1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 15; i++) exp_step("fo_hold_cnt", S_HOLD, 1'b1, 1'b1, 32'd0, 1'b0);
        exp_step("fo_off", S_OFF, 1'b0, 1'b0, 32'd0, 1'b0);

        // asynchronous reset in the middle of WAKE
        req = 4'b0001;
        exp_step("rst_wake", S_WAKE, 1'b1, 1'b0, 32'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        push("rst_async", S_OFF, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check();
        @(negedge clock);
        reset = 1'b0;
        exp_step("rst_rewake0", S_WAKE, 1'b1, 1'b0, 32'd1, 1'b1);
        exp_step("rst_rewake1", S_WAKE, 1'b1, 1'b0, 32'd1, 1'b1);
        exp_step("rst_on", S_ON, 1'b1, 1'b1, 32'd1, 1'b1);
        req = 4'b0000;

        // 4-bit counter saturates at 15
        r4 = 1'b0;
        repeat (13) step();
        exp_step4("sat4_14", 32'd14);
        exp_step4("sat4_15", 32'd15);
        repeat (4) step();
        exp_step4("sat4_20", 32'd15);
        exp_step4("sat4_21", 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
